// File: rtl/step_assembler.sv
// Byte-serial witness stream to 560-bit trace-step assembler.
// Collects one framed step into an accumulator while a completed step is held
// on the valid/ready output, so a full frame can be buffered behind a stalled
// consumer. Only the final beat of a frame can be back-pressured.
module step_assembler #(
  parameter int unsigned STEP_W = 560,
  parameter int unsigned BEAT_W = 8,
  parameter int unsigned BEATS  = 70
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BEAT_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_sof,
  output logic              in_ready,
  output logic [STEP_W-1:0] step,
  output logic              step_valid,
  input  logic              step_ready,
  output logic              frame_err,
  output logic [31:0]       step_count
);

  localparam int unsigned CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned ACC_BEATS = (BEATS > 1) ? BEATS - 1 : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  logic [CNT_W-1:0]                 beat_cnt;
  logic [CNT_W-1:0]                 beat_cnt_nxt;
  logic [ACC_BEATS-1:0][BEAT_W-1:0] acc;
  logic [ACC_BEATS-1:0][BEAT_W-1:0] acc_nxt;
  logic [STEP_W-1:0]                step_nxt;
  logic                             step_valid_nxt;
  logic                             frame_err_nxt;
  logic [31:0]                      step_count_nxt;

  logic is_last;
  logic accept;
  logic handoff;

  // Handshake decode; the last beat waits only while the output slot is occupied
  always_comb begin
    is_last  = (beat_cnt == LAST_BEAT);
    in_ready = !(is_last && step_valid && !step_ready);
    accept   = in_valid && in_ready;
    handoff  = step_valid && step_ready;
  end

  // Next-state: framing checks, beat capture, step completion and handoff
  always_comb begin
    beat_cnt_nxt   = beat_cnt;
    acc_nxt        = acc;
    step_nxt       = step;
    step_valid_nxt = step_valid && !handoff;
    frame_err_nxt  = 1'b0;
    step_count_nxt = step_count + 32'(handoff);

    if (accept) begin
      if (in_sof && (beat_cnt != '0)) begin
        // Early start of frame: drop the partial and restart on this beat
        acc_nxt[0]    = in_data;
        beat_cnt_nxt  = CNT_W'(1);
        frame_err_nxt = 1'b1;
      end else if (!in_sof && (beat_cnt == '0)) begin
        // Out of sync: discard beats until the next start of frame
        frame_err_nxt = 1'b1;
      end else if (is_last) begin
        step_nxt       = STEP_W'({in_data, acc});
        step_valid_nxt = 1'b1;
        beat_cnt_nxt   = '0;
      end else begin
        acc_nxt[beat_cnt] = in_data;
        beat_cnt_nxt      = beat_cnt + CNT_W'(1);
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt   <= '0;
      acc        <= '0;
      step       <= '0;
      step_valid <= 1'b0;
      frame_err  <= 1'b0;
      step_count <= '0;
    end else begin
      beat_cnt   <= beat_cnt_nxt;
      acc        <= acc_nxt;
      step       <= step_nxt;
      step_valid <= step_valid_nxt;
      frame_err  <= frame_err_nxt;
      step_count <= step_count_nxt;
    end
  end

endmodule
